mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32: address and write-data width in bits.
REQ-002 The block SHALL take parameter TIMEOUT, default 15: maximum BUSY cycles without mem_ready; 0 disables the timeout.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The ports SHALL be as follows:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  4  per-requester transaction request.
- lock  in  4  per-requester hold-grant for back-to-back transactions.
- addr  in  4*WIDTH  packed addresses; requester i at [i*WIDTH +: WIDTH].
- wdata  in  4*WIDTH  packed write data, same packing as addr.
- we  in  4  per-requester write enable.
- gnt  out  4  one-hot grant; all zero when idle.
- done  out  4  one-cycle completion pulse to the granted requester.
- err  out  4  one-cycle timeout pulse to the granted requester.
- sel  out  2  registered select, driving a 4:1 select datapath.
- busy  out  1  high in BUSY.
- mem_valid  out  1  shared-port request.
- mem_addr  out  WIDTH  addr of requester sel.
- mem_wdata  out  WIDTH  wdata of requester sel.
- mem_we  out  1  we[sel] when BUSY, else 0.
- mem_ready  in  1  shared port completes the current transaction this cycle.

Function
REQ-005 The FSM SHALL have exactly two states, IDLE and BUSY; busy = mem_valid = (state == BUSY).
REQ-006 In IDLE with any req bit set, the block SHALL pick the first requester at or after rr pointer ptr, scanning upward mod 4, latch sel and gnt at that edge, and enter BUSY; arbitration latency is 1 cycle.
REQ-007 In IDLE with req == 0, the block SHALL hold all state unchanged; mem_ready in IDLE SHALL be ignored.
REQ-008 mem_addr, mem_wdata and we[sel] SHALL be combinational selections of the live inputs of requester sel; requesters hold them stable while granted.
REQ-009 done[i] SHALL equal gnt[i] & mem_ready & BUSY, combinationally.
REQ-010 On a completion edge, ptr SHALL become sel+1 mod 4 (3 wraps to 0), except when lock[sel] & req[sel] is true.
REQ-011 On a completion edge with lock[sel] & req[sel] true, the block SHALL stay BUSY with unchanged sel, gnt and ptr (no idle bubble); otherwise it SHALL enter IDLE and clear gnt.
REQ-012 Once granted, the transaction SHALL continue if req[sel] drops; only mem_ready, timeout or reset ends it.
REQ-013 Counter cnt SHALL be 0 on BUSY entry and after each completion; each BUSY cycle without mem_ready increments it.
REQ-014 If TIMEOUT > 0 and cnt == TIMEOUT-1 in a BUSY cycle without mem_ready, err[sel] SHALL pulse that cycle, ptr SHALL become sel+1 mod 4, and the FSM SHALL enter IDLE regardless of lock.
REQ-015 mem_ready SHALL take priority over timeout in the same cycle; done and err SHALL never assert together.
REQ-016 cnt SHALL be wide enough for TIMEOUT without wrap; with TIMEOUT == 0, err SHALL never assert.

Reset
REQ-017 Reset SHALL force state IDLE, ptr 0, sel 0, gnt 0, cnt 0, so that busy, mem_valid, mem_we, done and err are 0 the cycle after.
REQ-018 Reset during BUSY SHALL abort the transaction with no done or err pulse; reset overrides all other inputs.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Single requester: req=0100, mem_ready high on the 2nd BUSY cycle -> gnt=0100, sel=2, done=0100 for one cycle, IDLE next, ptr=3.
- Full contention: req=1111, mem_ready tied 1, lock=0 -> grant order 0,1,2,3,0, each 1 BUSY + 1 IDLE cycle.
- Lock: req=0011, lock=0001, mem_ready=1 -> requester 0 completes 3 back-to-back without IDLE; drop lock -> requester 1 granted after one IDLE cycle.
- Timeout: TIMEOUT=3, req=1000, mem_ready=0 -> err=1000 in 3rd BUSY cycle, IDLE next, ptr=0; no done.
- Reset mid-BUSY: requester 2 granted, reset 1 cycle -> next cycle mem_valid=0, gnt=0, no done; then req=1001 -> requester 0 granted.
- Ready and timeout coincide: TIMEOUT=2, mem_ready on 2nd BUSY cycle -> done pulses, err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter giving one of four requesters the shared
// memory port, with per-requester grant lock and a bounded wait for mem_ready.
module mem_port_arbiter #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [3:0]         req,
   input  logic [3:0]         lock,
   input  logic [4*WIDTH-1:0] addr,
   input  logic [4*WIDTH-1:0] wdata,
   input  logic [3:0]         we,
   output logic [3:0]         gnt,
   output logic [3:0]         done,
   output logic [3:0]         err,
   output logic [1:0]         sel,
   output logic               busy,
   output logic               mem_valid,
   output logic [WIDTH-1:0]   mem_addr,
   output logic [WIDTH-1:0]   mem_wdata,
   output logic               mem_we,
   input  logic               mem_ready
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    ptr;
   logic [1:0]    ptr_nxt;
   logic [1:0]    sel_nxt;
   logic [1:0]    pick;
   logic [3:0]    gnt_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          hold;
   logic          tmo;

   // round-robin pick: lowest offset from ptr wins, so scan offsets downward
   always_comb begin
      pick = ptr;
      for (int k = 3; k >= 0; k--) begin
         if (req[ptr + 2'(k)]) begin
            pick = ptr + 2'(k);
         end
      end
   end

   assign hold = lock[sel] & req[sel];
   assign tmo  = (TIMEOUT > 0) && (cnt == CNT_LAST);

   // state and arbitration registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= 2'd0;
         sel   <= 2'd0;
         gnt   <= 4'b0000;
         cnt   <= {CW{1'b0}};
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         sel   <= sel_nxt;
         gnt   <= gnt_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // next-state and next-register values
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      sel_nxt   = sel;
      gnt_nxt   = gnt;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (req != 4'b0000) begin
               state_nxt = BUSY;
               sel_nxt   = pick;
               gnt_nxt   = 4'b0001 << pick;
               cnt_nxt   = {CW{1'b0}};
            end else begin
               state_nxt = IDLE;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               cnt_nxt = {CW{1'b0}};
               // a locked, still-requesting owner keeps the port with no idle bubble
               if (hold) begin
                  state_nxt = BUSY;
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = 4'b0000;
                  ptr_nxt   = sel + 2'd1;
               end
            end else if (tmo) begin
               state_nxt = IDLE;
               gnt_nxt   = 4'b0000;
               ptr_nxt   = sel + 2'd1;
               cnt_nxt   = {CW{1'b0}};
            end else begin
               state_nxt = BUSY;
               if (cnt != CNT_MAX) begin
                  cnt_nxt = cnt + CW'(1);
               end else begin
                  cnt_nxt = cnt;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
         end
      endcase
   end

   // outputs and shared-port datapath selection
   always_comb begin
      busy      = (state == BUSY);
      mem_valid = (state == BUSY);
      mem_addr  = addr[sel*WIDTH +: WIDTH];
      mem_wdata = wdata[sel*WIDTH +: WIDTH];
      mem_we    = (state == BUSY) & we[sel];
      if ((state == BUSY) && mem_ready) begin
         done = gnt;
         err  = 4'b0000;
      end else if ((state == BUSY) && tmo) begin
         done = 4'b0000;
         err  = gnt;
      end else begin
         done = 4'b0000;
         err  = 4'b0000;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (TIMEOUT 3, 2, 0) share stimulus and
// are compared every cycle against a transaction-level model, plus directed checks.
module tb_mem_port_arbiter;

   localparam int W = 16;

   logic           clock = 1'b0;
   logic           reset;
   logic [3:0]     req;
   logic [3:0]     lock;
   logic [4*W-1:0] addr;
   logic [4*W-1:0] wdata;
   logic [3:0]     we;
   logic           mem_ready;

   logic [3:0]   gnt_o       [3];
   logic [3:0]   done_o      [3];
   logic [3:0]   err_o       [3];
   logic [1:0]   sel_o       [3];
   logic         busy_o      [3];
   logic         mem_valid_o [3];
   logic [W-1:0] mem_addr_o  [3];
   logic [W-1:0] mem_wdata_o [3];
   logic         mem_we_o    [3];

   int vectors     = 0;
   int miscompares = 0;
   bit started     = 1'b0;

   int TV     [3] = '{3, 2, 0};
   int m_busy [3] = '{0, 0, 0};
   int m_sel  [3] = '{0, 0, 0};
   int m_ptr  [3] = '{0, 0, 0};
   int m_cnt  [3] = '{0, 0, 0};

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_port_arbiter #(.WIDTH(W), .TIMEOUT(g == 0 ? 3 : (g == 1 ? 2 : 0))) dut (
         .clock     (clock),
         .reset     (reset),
         .req       (req),
         .lock      (lock),
         .addr      (addr),
         .wdata     (wdata),
         .we        (we),
         .gnt       (gnt_o[g]),
         .done      (done_o[g]),
         .err       (err_o[g]),
         .sel       (sel_o[g]),
         .busy      (busy_o[g]),
         .mem_valid (mem_valid_o[g]),
         .mem_addr  (mem_addr_o[g]),
         .mem_wdata (mem_wdata_o[g]),
         .mem_we    (mem_we_o[g]),
         .mem_ready (mem_ready)
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // per-cycle comparison against the transaction model, then advance the model
   always @(negedge clock) begin
      logic [3:0] oh;
      logic [3:0] e_gnt;
      logic [3:0] e_done;
      logic [3:0] e_err;
      if (started) begin
         for (int k = 0; k < 3; k++) begin
            oh     = 4'b0001 << m_sel[k];
            e_gnt  = (m_busy[k] != 0) ? oh : 4'b0000;
            e_done = (m_busy[k] != 0 && mem_ready) ? oh : 4'b0000;
            e_err  = (m_busy[k] != 0 && !mem_ready && TV[k] > 0 && m_cnt[k] == TV[k] - 1)
                     ? oh : 4'b0000;
            chk($sformatf("gnt%0d", k), 32'(gnt_o[k]), 32'(e_gnt));
            chk($sformatf("done%0d", k), 32'(done_o[k]), 32'(e_done));
            chk($sformatf("err%0d", k), 32'(err_o[k]), 32'(e_err));
            chk($sformatf("sel%0d", k), 32'(sel_o[k]), 32'(m_sel[k]));
            chk($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(m_busy[k]));
            chk($sformatf("mvalid%0d", k), 32'(mem_valid_o[k]), 32'(m_busy[k]));
            chk($sformatf("maddr%0d", k), 32'(mem_addr_o[k]), 32'(addr[m_sel[k]*W +: W]));
            chk($sformatf("mwdata%0d", k), 32'(mem_wdata_o[k]), 32'(wdata[m_sel[k]*W +: W]));
            chk($sformatf("mwe%0d", k), 32'(mem_we_o[k]),
                32'((m_busy[k] != 0) && we[m_sel[k]]));
         end
         for (int k = 0; k < 3; k++) begin
            if (reset) begin
               m_busy[k] = 0; m_sel[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
            end else if (m_busy[k] == 0) begin
               if (req != 4'b0000) begin
                  for (int j = 3; j >= 0; j--) begin
                     if (req[(m_ptr[k] + j) % 4]) m_sel[k] = (m_ptr[k] + j) % 4;
                  end
                  m_busy[k] = 1;
                  m_cnt[k]  = 0;
               end
            end else if (mem_ready) begin
               m_cnt[k] = 0;
               if (!(lock[m_sel[k]] && req[m_sel[k]])) begin
                  m_busy[k] = 0;
                  m_ptr[k]  = (m_sel[k] + 1) % 4;
               end
            end else if (TV[k] > 0 && m_cnt[k] == TV[k] - 1) begin
               m_busy[k] = 0;
               m_ptr[k]  = (m_sel[k] + 1) % 4;
               m_cnt[k]  = 0;
            end else begin
               m_cnt[k]++;
            end
         end
      end
   end

   initial begin
      logic [3:0] e;
      reset = 1'b1; req = 4'b0000; lock = 4'b0000; we = 4'b0000; mem_ready = 1'b0;
      addr  = {4{16'h1234}}; wdata = {4{16'hbeef}};
      step();
      started = 1'b1;
      step();
      chk("reset_busy", 32'(busy_o[0]), 32'h0);
      chk("reset_gnt", 32'(gnt_o[0]), 32'h0);
      chk("reset_mwe", 32'(mem_we_o[0]), 32'h0);

      // single requester 2, ready on the 2nd BUSY cycle
      reset = 1'b0; req = 4'b0100; we = 4'b0100;
      step();
      chk("single_gnt", 32'(gnt_o[0]), 32'h4);
      chk("single_sel", 32'(sel_o[0]), 32'h2);
      req = 4'b0000;
      step();
      mem_ready = 1'b1; #1;
      chk("single_done", 32'(done_o[0]), 32'h4);
      chk("coincide_done", 32'(done_o[1]), 32'h4);
      chk("coincide_err", 32'(err_o[1]), 32'h0);
      step();
      mem_ready = 1'b0; #1;
      chk("single_idle", 32'(busy_o[0]), 32'h0);
      chk("single_done_off", 32'(done_o[0]), 32'h0);
      req = 4'b1111;
      step();
      chk("single_ptr3", 32'(gnt_o[0]), 32'h8);

      // full contention, ready tied high
      reset = 1'b1; req = 4'b0000;
      step();
      reset = 1'b0; req = 4'b1111; mem_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         step();
         e = 4'b0001 << (n % 4);
         chk($sformatf("rr_gnt%0d", n), 32'(gnt_o[0]), 32'(e));
         chk($sformatf("rr_done%0d", n), 32'(done_o[0]), 32'(e));
         step();
         chk($sformatf("rr_idle%0d", n), 32'(busy_o[0]), 32'h0);
      end

      // lock keeps requester 0 for three back-to-back completions
      reset = 1'b1; req = 4'b0000;
      step();
      reset = 1'b0; req = 4'b0011; lock = 4'b0001; mem_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         chk($sformatf("lock_busy%0d", n), 32'(busy_o[0]), 32'h1);
         chk($sformatf("lock_done%0d", n), 32'(done_o[0]), 32'h1);
      end
      lock = 4'b0000;
      step();
      chk("lock_bubble", 32'(busy_o[0]), 32'h0);
      step();
      chk("lock_next", 32'(gnt_o[0]), 32'h2);

      // timeout on requester 3
      reset = 1'b1; req = 4'b0000; mem_ready = 1'b0;
      step();
      reset = 1'b0; req = 4'b1000;
      step();
      chk("tmo_err_c1", 32'(err_o[0]), 32'h0);
      step();
      chk("tmo_err_c2", 32'(err_o[0]), 32'h0);
      step();
      chk("tmo_err_c3", 32'(err_o[0]), 32'h8);
      chk("tmo_done_c3", 32'(done_o[0]), 32'h0);
      chk("tmo_never_err", 32'(err_o[2]), 32'h0);
      chk("tmo_never_busy", 32'(busy_o[2]), 32'h1);
      step();
      chk("tmo_idle", 32'(busy_o[0]), 32'h0);
      req = 4'b1001;
      step();
      chk("tmo_ptr0", 32'(gnt_o[0]), 32'h1);

      // reset while BUSY
      reset = 1'b1; req = 4'b0000;
      step();
      reset = 1'b0; req = 4'b0100;
      step();
      chk("rstb_gnt", 32'(gnt_o[0]), 32'h4);
      reset = 1'b1;
      step();
      chk("rstb_valid", 32'(mem_valid_o[0]), 32'h0);
      chk("rstb_gnt0", 32'(gnt_o[0]), 32'h0);
      chk("rstb_done", 32'(done_o[0]), 32'h0);
      reset = 1'b0; req = 4'b1001;
      step();
      chk("rstb_regrant", 32'(gnt_o[0]), 32'h1);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 99) == 0);
         req       = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         lock      = 4'($urandom_range(0, 15));
         we        = 4'($urandom_range(0, 15));
         mem_ready = ($urandom_range(0, 2) == 0);
         addr      = {$urandom, $urandom};
         wdata     = {$urandom, $urandom};
         step();
      end

      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
